dequant_and_idct: RTL and testbench

Decoder-side counterpart of the DCT/quantization stage. It accepts one 8x8 block of quantized coefficients as a 512-bit flat vector. It multiplies each coefficient by the shared JPEG luminance quantization table, then runs a two-pass fixed-point 2-D IDCT using the same ×10000 cosine matrix as the encoder. It adds the +128 level shift, clamps to 0..255 and presents the reconstructed pixels as a 512-bit flat vector under a valid/ready handshake.

---
 rtl/jpeg_pkg.sv | 40 ++++
 rtl/idct_mac8.sv | 23 ++
 rtl/dequant_and_idct.sv | 138 +++++++++++++
 tb/tb_dequant_and_idct.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Constants shared by the JPEG encoder and decoder so both sides stay bit-consistent:
// the x10000 cosine matrix, the luminance quantization table and the flat-vector layout.
package jpeg_pkg;

    localparam int SCALE = 10000;
    localparam int ACC_W = 48;
    localparam int TMP_W = 32;

    typedef logic signed [7:0]       qcoef_t;
    typedef logic signed [15:0]      dcoef_t;
    typedef logic signed [TMP_W-1:0] tcoef_t;

    // COS_TAB[k][n] = c(k) * cos((2n+1)k*pi/16) * SCALE, rounded
    localparam int COS_TAB [8][8] = '{
        '{ 3536,  3536,  3536,  3536,  3536,  3536,  3536,  3536},
        '{ 4904,  4157,  2778,   975,  -975, -2778, -4157, -4904},
        '{ 4619,  1913, -1913, -4619, -4619, -1913,  1913,  4619},
        '{ 4157,  -975, -4904, -2778,  2778,  4904,   975, -4157},
        '{ 3536, -3536, -3536,  3536,  3536, -3536, -3536,  3536},
        '{ 2778, -4904,   975,  4157, -4157,  -975,  4904, -2778},
        '{ 1913, -4619,  4619, -1913, -1913,  4619, -4619,  1913},
        '{  975, -2778,  4157, -4904,  4904, -4157,  2778,  -975}
    };

    localparam int QUANT_TAB [8][8] = '{
        '{16, 11, 10, 16,  24,  40,  51,  61},
        '{12, 12, 14, 19,  26,  58,  60,  55},
        '{14, 13, 16, 24,  40,  57,  69,  56},
        '{14, 17, 22, 29,  51,  87,  80,  62},
        '{18, 22, 37, 56,  68, 109, 103,  77},
        '{24, 35, 55, 64,  81, 104, 113,  92},
        '{49, 64, 78, 87, 103, 121, 120, 101},
        '{72, 92, 95, 98, 112, 100, 103,  99}
    };

    function automatic int flat_lsb(input int i, input int j);
        return (i * 8 + j) * 8;
    endfunction

endpackage

// File: rtl/idct_mac8.sv
// Eight-term signed dot product, then divide by SCALE rounding half away from zero.
module idct_mac8
    import jpeg_pkg::*;
(
    input  logic signed [TMP_W-1:0] a [8],
    input  logic signed [31:0]      b [8],
    output logic signed [TMP_W-1:0] y
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] biased;

    always_comb begin
        acc = '0;
        for (int k = 0; k < 8; k++) begin
            acc = acc + ACC_W'(a[k]) * ACC_W'(b[k]);
        end
        // bias away from zero so the truncating divide rounds half away from zero
        biased = acc[ACC_W-1] ? acc - ACC_W'(SCALE / 2) : acc + ACC_W'(SCALE / 2);
        y      = TMP_W'(biased / ACC_W'(SCALE));
    end

endmodule

// File: rtl/dequant_and_idct.sv
// Dequantizes one 8x8 coefficient block and reconstructs pixels with a two-pass IDCT.
//   state | meaning
//   IDLE  | waiting for a coefficient block, coeff_ready high
//   DEQ   | 64 cycles: D = q * Q
//   PASS1 | 64 cycles: T = C^T * D
//   PASS2 | 64 cycles: pixels = clamp(T * C + 128) written to pixel_flat
//   OUT   | pixel_valid held until pixel_ready
module dequant_and_idct
    import jpeg_pkg::*;
(
    input  logic         Clock,
    input  logic         reset,
    input  logic         coeff_valid,
    output logic         coeff_ready,
    input  logic [511:0] coeff_flat,
    output logic         pixel_valid,
    input  logic         pixel_ready,
    output logic [511:0] pixel_flat
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DEQ   = 3'd1;
    localparam logic [2:0] S_PASS1 = 3'd2;
    localparam logic [2:0] S_PASS2 = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    logic [2:0] state;
    logic [5:0] idx;
    logic [2:0] ri;
    logic [2:0] cj;

    qcoef_t q_arr [8][8];
    dcoef_t d_arr [8][8];
    tcoef_t t_arr [8][8];

    tcoef_t             mac_a [8];
    logic signed [31:0] mac_b [8];
    tcoef_t             mac_y;
    tcoef_t             v;
    logic [7:0]         pix;

    assign ri = idx[5:3];
    assign cj = idx[2:0];

    // single MAC shared by both passes; only the operand selection differs
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            if (state == S_PASS2) begin
                mac_a[k] = t_arr[ri][k];
                mac_b[k] = COS_TAB[k][cj];
            end else begin
                mac_a[k] = TMP_W'(d_arr[k][cj]);
                mac_b[k] = COS_TAB[k][ri];
            end
        end
    end

    idct_mac8 u_mac (
        .a (mac_a),
        .b (mac_b),
        .y (mac_y)
    );

    always_comb begin
        v = mac_y + TMP_W'(128);
        if (v < 0)
            pix = 8'd0;
        else if (v > 255)
            pix = 8'd255;
        else
            pix = v[7:0];
    end

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            coeff_ready <= 1'b1;
            pixel_valid <= 1'b0;
            pixel_flat  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (coeff_valid) begin
                        state       <= S_DEQ;
                        idx         <= '0;
                        coeff_ready <= 1'b0;
                    end
                end
                S_DEQ: begin
                    idx <= idx + 6'd1;
                    if (idx == 6'd63) state <= S_PASS1;
                end
                S_PASS1: begin
                    idx <= idx + 6'd1;
                    if (idx == 6'd63) state <= S_PASS2;
                end
                S_PASS2: begin
                    pixel_flat[flat_lsb(int'(ri), int'(cj)) +: 8] <= pix;
                    idx <= idx + 6'd1;
                    if (idx == 6'd63) begin
                        state       <= S_OUT;
                        pixel_valid <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (pixel_ready) begin
                        state       <= S_IDLE;
                        pixel_valid <= 1'b0;
                        coeff_ready <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    idx         <= '0;
                    coeff_ready <= 1'b1;
                    pixel_valid <= 1'b0;
                end
            endcase
        end
    end

    // working arrays carry no reset; they are fully rewritten for every block
    always_ff @(posedge Clock) begin
        if (state == S_IDLE && coeff_valid) begin
            for (int i = 0; i < 8; i++) begin
                for (int j = 0; j < 8; j++) begin
                    q_arr[i][j] <= coeff_flat[flat_lsb(i, j) +: 8];
                end
            end
        end
        if (state == S_DEQ)
            d_arr[ri][cj] <= dcoef_t'(int'(q_arr[ri][cj]) * QUANT_TAB[ri][cj]);
        if (state == S_PASS1)
            t_arr[ri][cj] <= mac_y;
    end

endmodule

// File: tb/tb_dequant_and_idct.sv
// Directed bench for dequant_and_idct: constant blocks with hand-derived pixels,
// backpressure, mid-block reset and a round trip through a real-valued encoder model.
module tb_dequant_and_idct;

    logic         Clock = 1'b0;
    logic         reset;
    logic         coeff_valid;
    logic         coeff_ready;
    logic [511:0] coeff_flat;
    logic         pixel_valid;
    logic         pixel_ready;
    logic [511:0] pixel_flat;

    int total  = 0;
    int passed = 0;

    int ci [8][8];
    int src [8][8];
    int qt [8][8] = '{
        '{16, 11, 10, 16,  24,  40,  51,  61},
        '{12, 12, 14, 19,  26,  58,  60,  55},
        '{14, 13, 16, 24,  40,  57,  69,  56},
        '{14, 17, 22, 29,  51,  87,  80,  62},
        '{18, 22, 37, 56,  68, 109, 103,  77},
        '{24, 35, 55, 64,  81, 104, 113,  92},
        '{49, 64, 78, 87, 103, 121, 120, 101},
        '{72, 92, 95, 98, 112, 100, 103,  99}
    };
    int sample [8][8] = '{
        '{52, 55, 61,  66,  70,  61, 64, 73},
        '{63, 59, 55,  90, 109,  85, 69, 72},
        '{62, 59, 68, 113, 144, 104, 66, 73},
        '{63, 58, 71, 122, 154, 106, 70, 69},
        '{67, 61, 68, 104, 126,  88, 68, 70},
        '{79, 65, 60,  70,  77,  68, 58, 75},
        '{85, 71, 64,  59,  55,  61, 65, 83},
        '{87, 79, 69,  68,  65,  76, 78, 94}
    };

    localparam int TOL = 24;

    always #5 Clock = ~Clock;

    dequant_and_idct dut (
        .Clock       (Clock),
        .reset       (reset),
        .coeff_valid (coeff_valid),
        .coeff_ready (coeff_ready),
        .coeff_flat  (coeff_flat),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .pixel_flat  (pixel_flat)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic step;
        @(posedge Clock);
        #1;
    endtask

    function automatic real cosr(input int k, input int n);
        real ck;
        ck = (k == 0) ? $sqrt(0.125) : 0.5;
        return ck * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0);
    endfunction

    function automatic longint rnd(input longint a);
        if (a >= 0) return (a + 5000) / 10000;
        else        return (a - 5000) / 10000;
    endfunction

    function automatic logic [511:0] model(input logic [511:0] qf);
        longint d [8][8];
        longint t [8][8];
        longint acc;
        longint v;
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                d[i][j] = longint'($signed(qf[(i * 8 + j) * 8 +: 8])) * qt[i][j];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                acc = 0;
                for (int k = 0; k < 8; k++) acc += ci[k][i] * d[k][j];
                t[i][j] = rnd(acc);
            end
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                acc = 0;
                for (int k = 0; k < 8; k++) acc += t[i][k] * ci[k][j];
                v = rnd(acc) + 128;
                if (v < 0) v = 0;
                if (v > 255) v = 255;
                r[(i * 8 + j) * 8 +: 8] = 8'(v);
            end
        return r;
    endfunction

    // forward DCT + quantization of src, standing in for the encoder
    task automatic encode(output logic [511:0] f);
        real s;
        real qr;
        int  qi;
        f = '0;
        for (int u = 0; u < 8; u++)
            for (int w = 0; w < 8; w++) begin
                s = 0.0;
                for (int x = 0; x < 8; x++)
                    for (int y = 0; y < 8; y++)
                        s += cosr(u, x) * cosr(w, y) * real'(src[x][y] - 128);
                qr = s / real'(qt[u][w]);
                qi = (qr >= 0.0) ? $rtoi(qr + 0.5) : -$rtoi(-qr + 0.5);
                if (qi > 127) qi = 127;
                if (qi < -128) qi = -128;
                f[(u * 8 + w) * 8 +: 8] = 8'(qi);
            end
    endtask

    task automatic run_block(input string tag, input logic [511:0] qf, input logic [511:0] expv,
                             input int hold, input logic [511:0] pulse);
        int cyc;
        cyc = 0;
        coeff_flat  = qf;
        coeff_valid = 1'b1;
        while (!coeff_ready && cyc < 500) begin
            step;
            cyc++;
        end
        step;
        coeff_valid = 1'b0;
        coeff_flat  = ~qf;
        cyc = 0;
        while (!pixel_valid && cyc < 1000) begin
            step;
            cyc++;
        end
        check({tag, "_lat"}, 512'(cyc), 512'(192));
        check({tag, "_pix"}, pixel_flat, expv);
        for (int c = 0; c < hold; c++) begin
            if (c == 4) begin
                coeff_flat  = pulse;
                coeff_valid = 1'b1;
            end else begin
                coeff_valid = 1'b0;
            end
            step;
            check({tag, "_hold_valid"}, 512'(pixel_valid), 512'(1));
            check({tag, "_hold_pix"}, pixel_flat, expv);
            check({tag, "_hold_ready"}, 512'(coeff_ready), 512'(0));
        end
        coeff_valid = 1'b0;
        pixel_ready = 1'b1;
        step;
        pixel_ready = 1'b0;
        check({tag, "_release"}, 512'({pixel_valid, coeff_ready}), 512'(2'b01));
    endtask

    task automatic round_trip(input string tag);
        logic [511:0] qf;
        logic [511:0] expv;
        int worst;
        int e;
        encode(qf);
        expv = model(qf);
        coeff_flat  = qf;
        coeff_valid = 1'b1;
        run_block(tag, qf, expv, 0, '0);
        worst = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                e = int'(pixel_flat[(i * 8 + j) * 8 +: 8]) - src[i][j];
                if (e < 0) e = -e;
                if (e > worst) worst = e;
            end
        check({tag, "_err_within_tol"}, 512'(worst <= TOL), 512'(1));
    endtask

    initial begin
        logic [511:0] q_pos1;
        logic seen;
        for (int k = 0; k < 8; k++)
            for (int n = 0; n < 8; n++) begin
                real x;
                x = cosr(k, n) * 10000.0;
                ci[k][n] = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
            end
        q_pos1 = '0;
        q_pos1[7:0] = 8'd1;

        reset       = 1'b1;
        coeff_valid = 1'b0;
        pixel_ready = 1'b0;
        coeff_flat  = '0;
        #2;
        check("reset_coeff_ready", 512'(coeff_ready), 512'(1));
        check("reset_pixel_valid", 512'(pixel_valid), 512'(0));
        check("reset_pixel_flat", pixel_flat, '0);
        step;
        step;
        reset = 1'b0;

        run_block("zero",  '0,           {64{8'd128}}, 0, '0);
        run_block("q_p1",  q_pos1,       {64{8'd130}}, 0, '0);
        run_block("q_m1",  512'(8'hFF),  {64{8'd126}}, 0, '0);
        run_block("q_127", 512'(8'h7F),  {64{8'd255}}, 0, '0);
        run_block("q_m128", 512'(8'h80), {64{8'd0}},   0, '0);

        // a coeff_valid pulse during OUT must be ignored
        run_block("bp", q_pos1, {64{8'd130}}, 10, 512'(8'h7F));
        seen = 1'b0;
        for (int c = 0; c < 250; c++) begin
            step;
            if (pixel_valid) seen = 1'b1;
        end
        check("bp_pulse_ignored", 512'(seen), 512'(0));

        // reset in the middle of PASS1
        coeff_flat  = 512'(8'hFF);
        coeff_valid = 1'b1;
        step;
        coeff_valid = 1'b0;
        repeat (100) step;
        reset = 1'b1;
        #1;
        check("abort_coeff_ready", 512'(coeff_ready), 512'(1));
        check("abort_pixel_valid", 512'(pixel_valid), 512'(0));
        check("abort_pixel_flat", pixel_flat, '0);
        step;
        reset = 1'b0;
        run_block("after_abort", q_pos1, {64{8'd130}}, 0, '0);

        // sample block, then a gradient block straight after it
        src = sample;
        round_trip("rt_sample");
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                src[x][y] = 40 + 10 * x + 6 * y;
        round_trip("rt_gradient");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

endmodule
